rob_unit: RTL and testbench

- In-order reorder buffer for the out-of-order core, sitting between dispatch, the common data bus (CDB) and the register map.
- Allocates a tag per dispatched instruction and tells the regmap which tag will produce each destination register.
- Captures results broadcast on the CDB and commits them in program order to the regmap.
- Resolves source-operand lookups (regmap value, ROB entry, or CDB bypass) and raises a pipeline redirect on a mispredicted or redirecting head entry.

---
 rtl/rob_pkg.sv | 25 ++
 rtl/rob_src_bypass.sv | 37 +++
 rtl/rob_unit.sv | 147 ++++++++++++++
 tb/tb_rob_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: operation kinds and the stored entry layout.
package rob_pkg;

  localparam int ROB_DATA_W = 32;
  localparam int ROB_ADDR_W = 32;
  localparam int ROB_REG_W  = 5;

  typedef enum logic [1:0] {
    ROB_OP_INT = 2'd0,
    ROB_OP_BR  = 2'd1,
    ROB_OP_LD  = 2'd2,
    ROB_OP_STR = 2'd3
  } rob_op_t;

  typedef struct packed {
    logic                  rdy;
    logic                  redirect;
    rob_op_t               op;
    logic [ROB_ADDR_W-1:0] iaddr;
    logic [ROB_ADDR_W-1:0] addr;
    logic [ROB_DATA_W-1:0] data;
    logic [ROB_REG_W-1:0]  rdest;
  } rob_entry_t;

endpackage

// File: rtl/rob_src_bypass.sv
// Resolves one source operand from the regmap, a completed ROB entry, or the live CDB.
module rob_src_bypass
  import rob_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                  i_regmap_rdy,
  input  logic [DATA_WIDTH-1:0] i_regmap_data,
  input  logic [TAG_WIDTH-1:0]  i_regmap_tag,
  input  logic                  i_entry_rdy,
  input  logic [DATA_WIDTH-1:0] i_entry_data,
  input  logic                  i_cdb_en,
  input  logic [TAG_WIDTH-1:0]  i_cdb_tag,
  input  logic [DATA_WIDTH-1:0] i_cdb_data,
  output logic                  o_rdy,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [TAG_WIDTH-1:0]  o_tag
);

  always_comb begin
    o_rdy  = 1'b0;
    o_data = '0;
    o_tag  = i_regmap_tag;
    if (i_regmap_rdy) begin
      o_rdy  = 1'b1;
      o_data = i_regmap_data;
    end else if (i_entry_rdy) begin
      o_rdy  = 1'b1;
      o_data = i_entry_data;
    end else if (i_cdb_en && (i_cdb_tag == i_regmap_tag)) begin
      o_rdy  = 1'b1;
      o_data = i_cdb_data;
    end
  end

endmodule

// File: rtl/rob_unit.sv
// In-order reorder buffer: tag allocation, CDB capture, in-order commit and redirect flush.
module rob_unit
  import rob_pkg::*;
#(
  parameter int DATA_WIDTH     = ROB_DATA_W,
  parameter int ADDR_WIDTH     = ROB_ADDR_W,
  parameter int ROB_DEPTH      = 64,
  parameter int REG_ADDR_WIDTH = ROB_REG_W,
  localparam int TAG_WIDTH     = $clog2(ROB_DEPTH)
) (
  input  logic                        clk,
  input  logic                        n_rst,
  output logic                        o_redirect,
  output logic [ADDR_WIDTH-1:0]       o_redirect_addr,
  input  logic                        i_cdb_en,
  input  logic                        i_cdb_redirect,
  input  logic [TAG_WIDTH-1:0]        i_cdb_tag,
  input  logic [DATA_WIDTH-1:0]       i_cdb_data,
  input  logic [ADDR_WIDTH-1:0]       i_cdb_addr,
  input  logic                        i_dispatch_en,
  input  logic                        i_dispatch_rdy,
  input  logic [1:0]                  i_dispatch_op,
  input  logic [ADDR_WIDTH-1:0]       i_dispatch_iaddr,
  input  logic [DATA_WIDTH-1:0]       i_dispatch_data,
  input  logic [REG_ADDR_WIDTH-1:0]   i_dispatch_rdest,
  output logic [TAG_WIDTH-1:0]        o_dispatch_tag,
  output logic                        o_dispatch_stall,
  input  logic [2*REG_ADDR_WIDTH-1:0] i_lookup_rsrc,
  output logic [1:0]                  o_lookup_rdy,
  output logic [2*DATA_WIDTH-1:0]     o_lookup_data,
  output logic [2*TAG_WIDTH-1:0]      o_lookup_tag,
  output logic [2*REG_ADDR_WIDTH-1:0] o_regmap_rsrc,
  input  logic [1:0]                  i_regmap_rdy,
  input  logic [2*DATA_WIDTH-1:0]     i_regmap_data,
  input  logic [2*TAG_WIDTH-1:0]      i_regmap_tag,
  output logic                        o_dest_en,
  output logic [REG_ADDR_WIDTH-1:0]   o_dest_rdest,
  output logic [DATA_WIDTH-1:0]       o_dest_data,
  output logic                        o_tag_en,
  output logic [REG_ADDR_WIDTH-1:0]   o_tag_rdest,
  output logic [TAG_WIDTH-1:0]        o_tag_tag
);

  localparam int PTR_W = TAG_WIDTH + 1;

  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  rob_entry_t           mem_q [ROB_DEPTH];
  rob_entry_t           mem_d [ROB_DEPTH];
  logic [TAG_WIDTH-1:0] head_idx, tail_idx;
  rob_entry_t           head_e;
  logic                 full, empty, commit, redirect, accept;
  logic [1:0]           lkp_rdy;
  logic [2*DATA_WIDTH-1:0] lkp_data;
  logic [2*TAG_WIDTH-1:0]  lkp_tag;

  always_comb begin
    head_idx = head_q[TAG_WIDTH-1:0];
    tail_idx = tail_q[TAG_WIDTH-1:0];
    head_e   = mem_q[head_idx];
    empty    = (head_q == tail_q);
    full     = (head_idx == tail_idx) && (head_q[TAG_WIDTH] != tail_q[TAG_WIDTH]);
    commit   = !empty && head_e.rdy;
    redirect = commit && head_e.redirect;
    accept   = i_dispatch_en && !full && !redirect;
  end

  // Dispatch is applied after the CDB write so it wins on a shared index; a flush overrides both.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    if (i_cdb_en) begin
      mem_d[i_cdb_tag].rdy      = 1'b1;
      mem_d[i_cdb_tag].redirect = i_cdb_redirect;
      mem_d[i_cdb_tag].data     = i_cdb_data;
      mem_d[i_cdb_tag].addr     = i_cdb_addr;
    end
    if (accept) begin
      mem_d[tail_idx].rdy      = i_dispatch_rdy;
      mem_d[tail_idx].redirect = 1'b0;
      mem_d[tail_idx].op       = rob_op_t'(i_dispatch_op);
      mem_d[tail_idx].iaddr    = i_dispatch_iaddr;
      mem_d[tail_idx].data     = i_dispatch_data;
      mem_d[tail_idx].rdest    = i_dispatch_rdest;
      tail_d                   = tail_q + PTR_W'(1);
    end
    if (commit) head_d = head_q + PTR_W'(1);
    if (redirect) begin
      head_d = '0;
      tail_d = '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        mem_d[i].rdy      = 1'b0;
        mem_d[i].redirect = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      mem_q  <= mem_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_src
    logic [TAG_WIDTH-1:0] rtag;
    assign rtag = i_regmap_tag[g*TAG_WIDTH +: TAG_WIDTH];
    rob_src_bypass #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH)
    ) u_src (
      .i_regmap_rdy  (i_regmap_rdy[g]),
      .i_regmap_data (i_regmap_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .i_regmap_tag  (rtag),
      .i_entry_rdy   (mem_q[rtag].rdy),
      .i_entry_data  (mem_q[rtag].data),
      .i_cdb_en      (i_cdb_en),
      .i_cdb_tag     (i_cdb_tag),
      .i_cdb_data    (i_cdb_data),
      .o_rdy         (lkp_rdy[g]),
      .o_data        (lkp_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_tag         (lkp_tag[g*TAG_WIDTH +: TAG_WIDTH])
    );
  end

  // Every output is held at zero while reset is asserted, including the pass-through ones.
  assign o_redirect       = n_rst && redirect;
  assign o_redirect_addr  = n_rst ? head_e.addr : '0;
  assign o_dispatch_tag   = n_rst ? tail_idx : '0;
  assign o_dispatch_stall = n_rst && full;
  assign o_tag_en         = n_rst && accept;
  assign o_tag_rdest      = n_rst ? i_dispatch_rdest : '0;
  assign o_tag_tag        = n_rst ? tail_idx : '0;
  assign o_dest_en        = n_rst && commit && (head_e.op != ROB_OP_STR);
  assign o_dest_rdest     = n_rst ? head_e.rdest : '0;
  assign o_dest_data      = n_rst ? head_e.data : '0;
  assign o_regmap_rsrc    = n_rst ? i_lookup_rsrc : '0;
  assign o_lookup_rdy     = n_rst ? lkp_rdy : '0;
  assign o_lookup_data    = n_rst ? lkp_data : '0;
  assign o_lookup_tag     = n_rst ? lkp_tag : '0;

endmodule

// File: tb/tb_rob_unit.sv
// Directed self-checking bench for rob_unit with hand-computed expectations.
module tb_rob_unit;

  logic        clk;
  logic        n_rst;
  logic        o_redirect;
  logic [31:0] o_redirect_addr;
  logic        i_cdb_en, i_cdb_redirect;
  logic [5:0]  i_cdb_tag;
  logic [31:0] i_cdb_data, i_cdb_addr;
  logic        i_dispatch_en, i_dispatch_rdy;
  logic [1:0]  i_dispatch_op;
  logic [31:0] i_dispatch_iaddr, i_dispatch_data;
  logic [4:0]  i_dispatch_rdest;
  logic [5:0]  o_dispatch_tag;
  logic        o_dispatch_stall;
  logic [9:0]  i_lookup_rsrc;
  logic [1:0]  o_lookup_rdy;
  logic [63:0] o_lookup_data;
  logic [11:0] o_lookup_tag;
  logic [9:0]  o_regmap_rsrc;
  logic [1:0]  i_regmap_rdy;
  logic [63:0] i_regmap_data;
  logic [11:0] i_regmap_tag;
  logic        o_dest_en;
  logic [4:0]  o_dest_rdest;
  logic [31:0] o_dest_data;
  logic        o_tag_en;
  logic [4:0]  o_tag_rdest;
  logic [5:0]  o_tag_tag;

  int total = 0;
  int bad   = 0;

  rob_unit dut (
    .clk(clk), .n_rst(n_rst),
    .o_redirect(o_redirect), .o_redirect_addr(o_redirect_addr),
    .i_cdb_en(i_cdb_en), .i_cdb_redirect(i_cdb_redirect), .i_cdb_tag(i_cdb_tag),
    .i_cdb_data(i_cdb_data), .i_cdb_addr(i_cdb_addr),
    .i_dispatch_en(i_dispatch_en), .i_dispatch_rdy(i_dispatch_rdy),
    .i_dispatch_op(i_dispatch_op), .i_dispatch_iaddr(i_dispatch_iaddr),
    .i_dispatch_data(i_dispatch_data), .i_dispatch_rdest(i_dispatch_rdest),
    .o_dispatch_tag(o_dispatch_tag), .o_dispatch_stall(o_dispatch_stall),
    .i_lookup_rsrc(i_lookup_rsrc), .o_lookup_rdy(o_lookup_rdy),
    .o_lookup_data(o_lookup_data), .o_lookup_tag(o_lookup_tag),
    .o_regmap_rsrc(o_regmap_rsrc), .i_regmap_rdy(i_regmap_rdy),
    .i_regmap_data(i_regmap_data), .i_regmap_tag(i_regmap_tag),
    .o_dest_en(o_dest_en), .o_dest_rdest(o_dest_rdest), .o_dest_data(o_dest_data),
    .o_tag_en(o_tag_en), .o_tag_rdest(o_tag_rdest), .o_tag_tag(o_tag_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_cdb_en = 0; i_cdb_redirect = 0; i_cdb_tag = '0; i_cdb_data = '0; i_cdb_addr = '0;
    i_dispatch_en = 0; i_dispatch_rdy = 0; i_dispatch_op = 2'd0;
    i_dispatch_iaddr = '0; i_dispatch_data = '0; i_dispatch_rdest = '0;
    i_lookup_rsrc = '0; i_regmap_rdy = '0; i_regmap_data = '0; i_regmap_tag = '0;
  endtask

  task automatic apply_stimulus_dispatch(input logic [1:0] op, input logic rdy,
                                         input logic [4:0] rdest, input logic [31:0] data);
    i_dispatch_en = 1; i_dispatch_op = op; i_dispatch_rdy = rdy;
    i_dispatch_rdest = rdest; i_dispatch_data = data; i_dispatch_iaddr = 32'h1000;
  endtask

  task automatic pulse_reset();
    n_rst = 0;
    #2;
    n_rst = 1;
    #1;
  endtask

  initial begin
    clear_inputs();
    n_rst = 0;
    i_dispatch_en = 1;
    i_regmap_rdy  = 2'b11;
    #3;
    check_output("rst_tag_en", o_tag_en, 0);
    check_output("rst_stall", o_dispatch_stall, 0);
    check_output("rst_dest_en", o_dest_en, 0);
    check_output("rst_lookup_rdy", o_lookup_rdy, 0);
    check_output("rst_redirect", o_redirect, 0);
    @(negedge clk);
    clear_inputs();
    n_rst = 1;
    tick();

    apply_stimulus_dispatch(2'd0, 0, 5'd5, 32'h0);
    #1;
    check_output("disp0_tag", o_dispatch_tag, 0);
    check_output("disp0_tag_en", o_tag_en, 1);
    check_output("disp0_tag_rdest", o_tag_rdest, 5);
    check_output("disp0_tag_tag", o_tag_tag, 0);
    check_output("disp0_no_commit", o_dest_en, 0);
    tick();

    clear_inputs();
    i_cdb_en = 1; i_cdb_tag = 6'd0; i_cdb_data = 32'hDEADBEEF;
    #1;
    check_output("cdb0_not_yet", o_dest_en, 0);
    tick();

    clear_inputs();
    #1;
    check_output("commit0_en", o_dest_en, 1);
    check_output("commit0_rdest", o_dest_rdest, 5);
    check_output("commit0_data", o_dest_data, 32'hDEADBEEF);
    tick();
    check_output("empty_after_commit", o_dest_en, 0);
    check_output("next_tag_1", o_dispatch_tag, 1);

    for (int i = 1; i <= 3; i++) begin
      apply_stimulus_dispatch(2'd0, 0, i[4:0], 32'h0);
      tick();
    end
    clear_inputs();
    i_lookup_rsrc = {5'd2, 5'd1};
    i_regmap_rdy  = 2'b10;
    i_regmap_data = {32'hAAAAAAAA, 32'h0};
    i_regmap_tag  = {6'd9, 6'd3};
    i_cdb_en = 1; i_cdb_tag = 6'd3; i_cdb_data = 32'h55;
    #1;
    check_output("lkp_rsrc", o_regmap_rsrc, {5'd2, 5'd1});
    check_output("lkp_bypass_rdy", o_lookup_rdy, 2'b11);
    check_output("lkp_bypass_data", o_lookup_data, {32'hAAAAAAAA, 32'h55});
    check_output("lkp_tags", o_lookup_tag, {6'd9, 6'd3});
    tick();

    clear_inputs();
    i_regmap_tag = {6'd2, 6'd3};
    #1;
    check_output("lkp_entry_rdy", o_lookup_rdy, 2'b01);
    check_output("lkp_entry_data", o_lookup_data, {32'h0, 32'h55});
    check_output("head1_pending", o_dest_en, 0);
    i_cdb_en = 1; i_cdb_tag = 6'd1; i_cdb_data = 32'h11;
    tick();
    i_cdb_tag = 6'd2; i_cdb_data = 32'h22;
    #1;
    check_output("drain1_data", o_dest_data, 32'h11);
    check_output("drain1_rdest", o_dest_rdest, 1);
    tick();
    clear_inputs();
    #1;
    check_output("drain2_data", o_dest_data, 32'h22);
    tick();
    check_output("drain3_en", o_dest_en, 1);
    check_output("drain3_data", o_dest_data, 32'h55);
    check_output("drain3_rdest", o_dest_rdest, 3);
    tick();
    check_output("drained", o_dest_en, 0);

    pulse_reset();
    for (int i = 0; i < 64; i++) begin
      apply_stimulus_dispatch(2'd0, 0, i[4:0], 32'h0);
      #1;
      check_output("fill_tag", o_dispatch_tag, i[5:0]);
      if (i == 63) check_output("fill_no_stall", o_dispatch_stall, 0);
      tick();
    end
    check_output("full_stall", o_dispatch_stall, 1);
    check_output("full_no_accept", o_tag_en, 0);
    check_output("full_tail_wrap", o_dispatch_tag, 0);
    clear_inputs();
    i_cdb_en = 1; i_cdb_tag = 6'd0; i_cdb_data = 32'h1234;
    tick();
    clear_inputs();
    #1;
    check_output("full_commit_stall", o_dispatch_stall, 1);
    check_output("full_commit_en", o_dest_en, 1);
    check_output("full_commit_data", o_dest_data, 32'h1234);
    tick();
    check_output("stall_cleared", o_dispatch_stall, 0);
    apply_stimulus_dispatch(2'd0, 0, 5'd30, 32'h0);
    #1;
    check_output("wrap_tag", o_tag_tag, 0);
    check_output("wrap_tag_en", o_tag_en, 1);
    tick();
    clear_inputs();
    #1;
    check_output("refull_stall", o_dispatch_stall, 1);

    pulse_reset();
    apply_stimulus_dispatch(2'd1, 0, 5'd6, 32'h0);
    #1;
    check_output("br_tag", o_dispatch_tag, 0);
    tick();
    apply_stimulus_dispatch(2'd0, 0, 5'd7, 32'h0);
    i_cdb_en = 1; i_cdb_tag = 6'd0; i_cdb_redirect = 1;
    i_cdb_addr = 32'h100; i_cdb_data = 32'h0;
    #1;
    check_output("int_tag", o_dispatch_tag, 1);
    tick();
    clear_inputs();
    apply_stimulus_dispatch(2'd0, 0, 5'd9, 32'h0);
    i_cdb_en = 1; i_cdb_tag = 6'd1; i_cdb_data = 32'h22;
    #1;
    check_output("redir", o_redirect, 1);
    check_output("redir_addr", o_redirect_addr, 32'h100);
    check_output("redir_dest_en", o_dest_en, 1);
    check_output("redir_dest_rdest", o_dest_rdest, 6);
    check_output("redir_no_dispatch", o_tag_en, 0);
    tick();
    clear_inputs();
    #1;
    check_output("post_redir", o_redirect, 0);
    check_output("flushed_no_commit", o_dest_en, 0);
    check_output("flushed_tail", o_dispatch_tag, 0);

    apply_stimulus_dispatch(2'd3, 1, 5'd3, 32'h77);
    #1;
    check_output("str_tag", o_dispatch_tag, 0);
    tick();
    apply_stimulus_dispatch(2'd0, 1, 5'd4, 32'h99);
    #1;
    check_output("str_commit_no_dest", o_dest_en, 0);
    check_output("str_head_rdest", o_dest_rdest, 3);
    check_output("after_str_tag", o_dispatch_tag, 1);
    tick();
    clear_inputs();
    #1;
    check_output("post_str_en", o_dest_en, 1);
    check_output("post_str_rdest", o_dest_rdest, 4);
    check_output("post_str_data", o_dest_data, 32'h99);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
